aes_subshift_serial: RTL and testbench
======================================

// Module: aes_subshift_serial
// PURPOSE
//  AES round front end: applies SubBytes then ShiftRows to a 128-bit state.
//  Sits directly upstream of the MixColumns stage; out/finish drive its a/start.
//  Processes the state with NUM_SBOX shared S-box instances over 16/NUM_SBOX
//  cycles, trading area for latency.
// PARAMETERS
//  NUM_SBOX  16  S-box instances used in parallel; legal 1,2,4,8,16.
//                Any other value is an elaboration error.
// PORTS
//  clk     in   1    single clock, all flops rising-edge
//  rst     in   1    synchronous, active-high reset
//  start   in   1    request; sampled only when busy=0
//  a       in   128  input state; sampled together with accepted start
//  busy    out  1    1 while a state is being processed (RUN)
//  finish  out  1    1-cycle pulse: out is valid
//  out     out  128  SubBytes+ShiftRows result; held until next completion
// BEHAVIOUR
//  - Byte map (in and out): byte k = 4*c+r (column c, row r) at [127-8k -: 8].
//    a[127:120] is r0c0; a[119:112] is r1c0.
//  - Function: out[r][c] = SBOX(a[r][(c+r)%4]) (FIPS-197 forward S-box).
//  - Reset: state=IDLE, busy=0, finish=0, out=128'h0, cnt=0, capture reg=0.
//    Reset mid-operation aborts the operation. No finish is produced.
//  - FSM IDLE/RUN/DONE:
//    IDLE: start=1 -> latch a, cnt=0, go RUN.
//    RUN: each cycle substitutes input bytes cnt*NUM_SBOX .. cnt*NUM_SBOX+NUM_SBOX-1.
//         Each result is written to its ShiftRows destination in out.
//         cnt++. At cnt=16/NUM_SBOX-1 the write completes and the FSM goes DONE.
//    DONE: finish=1 for exactly this cycle. start=1 here is accepted like in IDLE
//          and goes RUN; otherwise go IDLE.
//  - Latency: start high in cycle 0 -> finish high in cycle 16/NUM_SBOX+1.
//    NUM_SBOX=16 gives cycle 2; NUM_SBOX=1 gives cycle 17.
//  - Back-to-back: start held high gives one result every 16/NUM_SBOX+1 cycles.
//  - busy = (state==RUN). start is ignored while busy=1, and a is not re-sampled.
//  - out is written only in RUN. Intermediate values during RUN are undefined to
//    consumers. out stays stable from the finish cycle until the next RUN.
//  - finish and out are registered; no combinational path from start/a to outputs.
//  - cnt width: $clog2(16/NUM_SBOX), minimum 1 bit. cnt wraps to 0 on entry to RUN.
//  - S-box: a combinational 256-entry table function, instantiated NUM_SBOX
//    times. No other arithmetic.
// TESTING
//  1) FIPS-197 App.B round 1: a=193de3bea0f4e22b9ac68d2ae9f84808
//     -> out=d4bf5d30e0b452aeb84111f11e2798e5, finish one cycle.
//  2) a=0 -> out=636363...63 (16 bytes); a=all FF -> out=16161616...16.
//  3) Latency sweep over NUM_SBOX in {1,2,4,8,16}: finish in cycle 16/N+1 after
//     start. busy=1 for exactly 16/N cycles.
//  4) start pulsed again during RUN with a different a -> ignored; result is the
//     first state's; a single finish.
//  5) start held high 3 ops with vectors 1, 2, 1 -> three finish pulses
//     16/N+1 cycles apart, each out correct.
//  6) rst asserted mid-RUN -> next cycle busy=0, finish=0, out=0. A new start then
//     completes normally.

Source files
------------

// File: rtl/aes_subshift_serial.sv
// AES SubBytes + ShiftRows front end, processing NUM_SBOX bytes per cycle
// through shared S-box lookups. Results are scattered into their ShiftRows slots.
module aes_subshift_serial #(
  parameter int NUM_SBOX = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] a,
  output logic         busy,
  output logic         finish,
  output logic [127:0] out
);

  localparam int STEPS = 16 / NUM_SBOX;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 &&
      NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
    $error("aes_subshift_serial: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 forward S-box; entry x sits at bits [2047-8x -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[2047 - 8*x -: 8];
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [127:0]       a_q,     a_d;
  logic [127:0]       out_q,   out_d;
  logic               finish_q, finish_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    out_d    = out_q;
    finish_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NUM_SBOX; i++) begin
          logic [3:0] src;
          logic [1:0] dst_col;
          src = 4'(int'(cnt_q) * NUM_SBOX + i);
          // Row r shifts left by r columns: input column c lands in column c-r.
          dst_col = src[3:2] - src[1:0];
          out_d[127 - 8*{dst_col, src[1:0]} -: 8] = sbox(a_q[127 - 8*src -: 8]);
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          finish_d = 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          a_d     = a;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      // NOTE: the capture register is reset too, so no stale state survives an abort.
      a_q      <= '0;
      out_q    <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      out_q    <= out_d;
      finish_q <= finish_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign finish = finish_q;
  assign out    = out_q;

endmodule

// File: tb/tb_aes_subshift_serial.sv
// Directed bench for aes_subshift_serial: one instance per legal NUM_SBOX,
// each checked against hand-computed vectors and its own expected latency.
module tb_aes_subshift_serial;

  localparam int NI = 5;  // instance i uses NUM_SBOX = 1<<i

  localparam logic [127:0] V_FIPS = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] E_FIPS = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] V_ZERO = 128'h00000000000000000000000000000000;
  localparam logic [127:0] E_ZERO = 128'h63636363636363636363636363636363;
  localparam logic [127:0] V_ONES = 128'hffffffffffffffffffffffffffffffff;
  localparam logic [127:0] E_ONES = 128'h16161616161616161616161616161616;
  localparam logic [127:0] V_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] E_SEQ  = 128'h636b6776f201ab7b30d777c5fe7c6f2b;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_w  [NI];
  logic [127:0] a_w      [NI];
  logic         busy_w   [NI];
  logic         finish_w [NI];
  logic [127:0] out_w    [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    aes_subshift_serial #(.NUM_SBOX(1 << g)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start_w[g]),
      .a      (a_w[g]),
      .busy   (busy_w[g]),
      .finish (finish_w[g]),
      .out    (out_w[g])
    );
  end

  function automatic int lat(input int i);
    return 16 / (1 << i) + 1;
  endfunction

  task automatic drive_all(input logic st, input logic [127:0] v);
    for (int i = 0; i < NI; i++) begin
      start_w[i] = st;
      a_w[i]     = v;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_all(1'b0, V_ZERO);
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (busy_w[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_busy N=%0d: got %b want 0", 1 << i, busy_w[i]);
      end
      n_checks++;
      if (finish_w[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_finish N=%0d: got %b want 0", 1 << i, finish_w[i]);
      end
      n_checks++;
      if (out_w[i] !== 128'h0) begin
        n_fail++;
        $display("FAIL reset_out N=%0d: got %h want 0", 1 << i, out_w[i]);
      end
    end
    rst = 1'b0;
  endtask

  // One operation per instance; also checks latency, busy window and hold of out.
  task automatic test_single_op(input string name, input logic [127:0] v,
                                input logic [127:0] e);
    for (int j = 0; j <= 18; j++) begin
      @(negedge clk);
      if (j > 0) begin
        for (int i = 0; i < NI; i++) begin
          logic exp_fin, exp_busy;
          exp_fin  = (j == lat(i));
          exp_busy = (j < lat(i));
          n_checks++;
          if (finish_w[i] !== exp_fin) begin
            n_fail++;
            $display("FAIL %s_finish N=%0d cycle %0d: got %b want %b",
                     name, 1 << i, j, finish_w[i], exp_fin);
          end
          n_checks++;
          if (busy_w[i] !== exp_busy) begin
            n_fail++;
            $display("FAIL %s_busy N=%0d cycle %0d: got %b want %b",
                     name, 1 << i, j, busy_w[i], exp_busy);
          end
          if (j == lat(i) || j == 18) begin
            n_checks++;
            if (out_w[i] !== e) begin
              n_fail++;
              $display("FAIL %s_out N=%0d cycle %0d: got %h want %h",
                       name, 1 << i, j, out_w[i], e);
            end
          end
        end
      end
      if (j == 0) drive_all(1'b1, v);
      else        drive_all(1'b0, ~v);
    end
  endtask

  task automatic test_ignore_start();
    int fin_cnt [NI];
    for (int i = 0; i < NI; i++) fin_cnt[i] = 0;
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk);
      if (j > 0) begin
        for (int i = 0; i < NI; i++) begin
          if (finish_w[i] === 1'b1) fin_cnt[i]++;
          if (j == lat(i)) begin
            n_checks++;
            if (finish_w[i] !== 1'b1 || out_w[i] !== E_FIPS) begin
              n_fail++;
              $display("FAIL ignore_result N=%0d cycle %0d: got finish=%b out=%h want finish=1 out=%h",
                       1 << i, j, finish_w[i], out_w[i], E_FIPS);
            end
          end
        end
      end
      if (j == 0)      drive_all(1'b1, V_FIPS);
      else if (j == 1) drive_all(1'b1, V_ONES);
      else             drive_all(1'b0, V_ONES);
    end
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (fin_cnt[i] != 1 || busy_w[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL ignore_count N=%0d: got finishes=%0d busy=%b want finishes=1 busy=0",
                 1 << i, fin_cnt[i], busy_w[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] vecs [3];
    logic [127:0] exps [3];
    vecs = '{V_FIPS, V_ZERO, V_FIPS};
    exps = '{E_FIPS, E_ZERO, E_FIPS};
    for (int j = 0; j <= 3 * 17 + 2; j++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        int   l;
        logic exp_fin, exp_busy;
        l = lat(i);
        if (j > 0) begin
          exp_fin  = (j % l == 0) && (j <= 3 * l);
          exp_busy = (j % l != 0) && (j < 3 * l);
          n_checks++;
          if (finish_w[i] !== exp_fin) begin
            n_fail++;
            $display("FAIL b2b_finish N=%0d cycle %0d: got %b want %b",
                     1 << i, j, finish_w[i], exp_fin);
          end
          n_checks++;
          if (busy_w[i] !== exp_busy) begin
            n_fail++;
            $display("FAIL b2b_busy N=%0d cycle %0d: got %b want %b",
                     1 << i, j, busy_w[i], exp_busy);
          end
          if (exp_fin) begin
            n_checks++;
            if (out_w[i] !== exps[j / l - 1]) begin
              n_fail++;
              $display("FAIL b2b_out N=%0d cycle %0d: got %h want %h",
                       1 << i, j, out_w[i], exps[j / l - 1]);
            end
          end
        end
        start_w[i] = (j <= 2 * l);
        a_w[i]     = (j <= 2 * l) ? vecs[j / l] : V_ONES;
      end
    end
  endtask

  task automatic test_reset_mid_run();
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (j == 1) begin
          n_checks++;
          if (busy_w[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre_busy N=%0d: got %b want 1", 1 << i, busy_w[i]);
          end
        end else if (j == 2) begin
          n_checks++;
          if (busy_w[i] !== 1'b0 || finish_w[i] !== 1'b0 || out_w[i] !== 128'h0) begin
            n_fail++;
            $display("FAIL midrst_state N=%0d: got busy=%b finish=%b out=%h want 0 0 0",
                     1 << i, busy_w[i], finish_w[i], out_w[i]);
          end
        end else if (j > 2) begin
          n_checks++;
          if (finish_w[i] !== 1'b0 || busy_w[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_quiet N=%0d cycle %0d: got busy=%b finish=%b want 0 0",
                     1 << i, j, busy_w[i], finish_w[i]);
          end
        end
      end
      if (j == 0) drive_all(1'b1, V_FIPS);
      else        drive_all(1'b0, V_ONES);
      rst = (j == 1);
    end
    test_single_op("restart", V_SEQ, E_SEQ);
  endtask

  initial begin
    test_reset();
    test_single_op("fips", V_FIPS, E_FIPS);
    test_single_op("zeros", V_ZERO, E_ZERO);
    test_single_op("ones", V_ONES, E_ONES);
    test_single_op("seq", V_SEQ, E_SEQ);
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
